// File: rtl/arya_mem_loader.sv
// arya_mem_loader
// Host-side loader and port-B arbiter for the Arya core's dual-port memory.
// In RUN the core's load/store requests pass straight through to port B.
// A host mode request (setup_mem / verify_mem) freezes the core. The host
// then gets word-at-a-time write (SETUP) or read-back (VERIFY) access, and
// the core is released afterwards. The core is restarted from PC 0 only
// when a SETUP session took place.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   en                         external run enable for the core
//   setup_mem, verify_mem      host mode requests (levels)
//   host_req                   one-cycle host transfer strobe
//   mem_addr_in, mem_data_in   host word address / write data
//   mem_data_out               registered read-back data
//   host_ack                   one-cycle transfer-complete pulse
//   loader_busy                high whenever the core is not running
//   load_count                 words written in the last/current setup session
//   core_en_out, core_reset_out  core enable / core reset
//   core_addr_in, core_data_in, core_we_in  core's port-B request
//   mem_addrb, mem_dinb, mem_web, mem_doutb  memory port B (1-cycle read latency)
//
// state    | meaning
// RUN      | core running, port B passed through from the core
// QUIESCE  | one cycle: core frozen, mode chosen
// SETUP    | host writes, one word per cycle
// VERIFY   | host read-back, one word per three cycles
// RELEASE  | one cycle: core still frozen, reset pulsed if SETUP occurred
module arya_mem_loader #(
   parameter int DATAPATH_WIDTH = 64,
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      en,
   input  logic                      setup_mem,
   input  logic                      verify_mem,
   input  logic                      host_req,
   input  logic [MEM_ADDR_WIDTH-1:0] mem_addr_in,
   input  logic [DATAPATH_WIDTH-1:0] mem_data_in,
   output logic [DATAPATH_WIDTH-1:0] mem_data_out,
   output logic                      host_ack,
   output logic                      loader_busy,
   output logic [MEM_ADDR_WIDTH:0]   load_count,
   output logic                      core_en_out,
   output logic                      core_reset_out,
   input  logic [MEM_ADDR_WIDTH-1:0] core_addr_in,
   input  logic [DATAPATH_WIDTH-1:0] core_data_in,
   input  logic                      core_we_in,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addrb,
   output logic [DATAPATH_WIDTH-1:0] mem_dinb,
   output logic                      mem_web,
   input  logic [DATAPATH_WIDTH-1:0] mem_doutb
);

   typedef enum logic [2:0] {
      ST_RUN,
      ST_QUIESCE,
      ST_SETUP,
      ST_VERIFY,
      ST_RELEASE
   } state_t;

   localparam logic [MEM_ADDR_WIDTH:0] COUNT_MAX = '1;
   localparam logic [MEM_ADDR_WIDTH:0] COUNT_ONE = {{MEM_ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                    state, state_nxt;
   logic                      wr_pend;
   logic                      rd_addr_ph;
   logic                      rd_data_ph;
   logic                      rd_ack;
   logic                      setup_seen;
   logic [MEM_ADDR_WIDTH-1:0] addr_q;
   logic [DATAPATH_WIDTH-1:0] data_q;
   logic                      accept_wr;
   logic                      accept_rd;
   logic                      xfer_pend;

   // A read occupies the address and data phases; requests during them are dropped.
   assign accept_wr = (state == ST_SETUP) && host_req;
   assign accept_rd = (state == ST_VERIFY) && host_req && !rd_addr_ph && !rd_data_ph;
   // A transfer being accepted this edge also holds off a mode change,
   // so it always completes in the mode that accepted it.
   assign xfer_pend = wr_pend || rd_addr_ph || rd_data_ph || accept_wr || accept_rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= ST_RUN;
         wr_pend      <= 1'b0;
         rd_addr_ph   <= 1'b0;
         rd_data_ph   <= 1'b0;
         rd_ack       <= 1'b0;
         setup_seen   <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         mem_data_out <= '0;
         load_count   <= '0;
      end else begin
         state      <= state_nxt;
         wr_pend    <= accept_wr;
         rd_addr_ph <= accept_rd;
         rd_data_ph <= rd_addr_ph;
         rd_ack     <= rd_data_ph;
         if (accept_wr || accept_rd) begin
            addr_q <= mem_addr_in;
         end
         if (accept_wr) begin
            data_q <= mem_data_in;
         end
         if (rd_data_ph) begin
            mem_data_out <= mem_doutb;
         end
         if (state == ST_QUIESCE && state_nxt == ST_SETUP) begin
            load_count <= '0;
         end else if (wr_pend && load_count != COUNT_MAX) begin
            load_count <= load_count + COUNT_ONE;
         end
         if (state == ST_RUN && state_nxt == ST_QUIESCE) begin
            setup_seen <= 1'b0;
         end else if (state_nxt == ST_SETUP) begin
            setup_seen <= 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_RUN: begin
            if (setup_mem || verify_mem) state_nxt = ST_QUIESCE;
         end
         ST_QUIESCE: begin
            state_nxt = setup_mem ? ST_SETUP : ST_VERIFY;
         end
         ST_SETUP: begin
            if (!xfer_pend && !setup_mem) begin
               state_nxt = verify_mem ? ST_VERIFY : ST_RELEASE;
            end
         end
         ST_VERIFY: begin
            if (!xfer_pend) begin
               if (setup_mem) state_nxt = ST_SETUP;
               else if (!verify_mem) state_nxt = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            state_nxt = ST_RUN;
         end
         default: begin
            state_nxt = ST_RUN;
         end
      endcase
   end

   always_comb begin
      loader_busy    = (state != ST_RUN);
      core_en_out    = (state == ST_RUN) && en;
      core_reset_out = reset || (state == ST_RELEASE && setup_seen);
      host_ack       = wr_pend || rd_ack;
      if (state == ST_RUN) begin
         mem_addrb = core_addr_in;
         mem_dinb  = core_data_in;
         mem_web   = core_we_in && !reset;
      end else begin
         mem_addrb = addr_q;
         mem_dinb  = data_q;
         mem_web   = wr_pend;
      end
   end

endmodule

// File: doc/arya_mem_loader.md
# arya_mem_loader

Host-side loader and port-B arbiter for the Arya core's dual-port memory. Owns port B of the shared instruction/data memory and the core's `en`/`reset` lines. In normal running it passes the core's load/store traffic straight through. When the host raises `setup_mem` or `verify_mem`, it freezes the core, gives the host word-at-a-time write or read-back access, then releases the core; after a setup session it restarts the core from PC 0.

## Interface
Parameters:
- `DATAPATH_WIDTH`, 64, memory word width
- `MEM_ADDR_WIDTH`, 10, memory address width (full space: instruction and data halves)

Ports:
- `clk`  in  1  single clock for the block
- `reset`  in  1  asynchronous, active-high
- `en`  in  1  external run enable
- `setup_mem`  in  1  host write mode request (level)
- `verify_mem`  in  1  host read-back mode request (level)
- `host_req`  in  1  one-cycle host transfer strobe
- `mem_addr_in`  in  MEM_ADDR_WIDTH  host word address
- `mem_data_in`  in  DATAPATH_WIDTH  host write data
- `mem_data_out`  out  DATAPATH_WIDTH  read-back data (registered)
- `host_ack`  out  1  one-cycle transfer-complete pulse
- `loader_busy`  out  1  high whenever the core is not running
- `load_count`  out  MEM_ADDR_WIDTH+1  words written in the last/current setup session
- `core_en_out`  out  1  enable to all core pipeline stages
- `core_reset_out`  out  1  reset to the core
- `core_addr_in`, `core_data_in`, `core_we_in`  in  MEM_ADDR_WIDTH / DATAPATH_WIDTH / 1  core's port-B request
- `mem_addrb`, `mem_dinb`, `mem_web`  out  MEM_ADDR_WIDTH / DATAPATH_WIDTH / 1  to memory port B
- `mem_doutb`  in  DATAPATH_WIDTH  from memory port B (1-cycle read latency)

## Operation
- **States:** RUN, QUIESCE, SETUP, VERIFY, RELEASE. Reset state is RUN.
- **RUN:**
  - `core_en_out = en`.
  - Port B is combinationally connected to `core_*`.
  - `host_req` is ignored.
- **RUN -> QUIESCE** when `setup_mem | verify_mem`.
- **QUIESCE** lasts 1 cycle:
  - `core_en_out = 0`.
  - Port B is driven by the loader with `mem_web = 0`; `core_we_in` is blocked in every non-RUN state.
  - Exits to SETUP if `setup_mem`, else to VERIFY. Setup has priority when both are high.
  - On entry to SETUP, `load_count` is cleared to 0.
- **SETUP:**
  - A `host_req` sampled high registers address and data; the write happens on the next cycle (`mem_web = 1` for exactly that cycle).
  - `host_ack` pulses in the same cycle as the write.
  - `load_count` increments per write and saturates at all-ones.
- **VERIFY:**
  - A `host_req` sampled high drives `mem_addrb` the next cycle.
  - `mem_doutb` is registered into `mem_data_out` one cycle later, with `host_ack` pulsing in the cycle `mem_data_out` first becomes valid.
  - `mem_data_out` holds until the next read completes.
  - `host_req` arriving while a read is in flight is dropped (no ack).
- **Mode switch:**
  - SETUP -> VERIFY when `setup_mem` falls and `verify_mem` is high.
  - VERIFY -> SETUP when `setup_mem` rises.
  - Any pending transfer completes first.
- **Exit:** when both mode inputs are low and no transfer is pending, go to RELEASE.
- **RELEASE** lasts 1 cycle:
  - `core_en_out = 0`.
  - `core_reset_out = 1` if a SETUP state occurred since leaving RUN.
  - Then RUN.
- **Outputs:**
  - `core_reset_out = reset | release_pulse`.
  - `loader_busy = (state != RUN)`.
- **Reset (any time, including mid-transfer):**
  - State returns to RUN and any pending op is discarded.
  - `host_ack = 0`, `mem_data_out = 0`, `load_count = 0`, `mem_web = 0`.
  - `core_en_out` follows `en`; `core_reset_out = 1` while `reset` is high.

## Timing
- Mode entry: `core_en_out` falls in the first cycle after `setup_mem`/`verify_mem` is sampled high; the first host transfer is accepted 2 cycles after the mode input is first sampled high.
- Write: `host_req` at edge N -> `mem_web = 1` and `host_ack = 1` during cycle N+1. Back-to-back `host_req` every cycle is allowed: 1 write per cycle.
- Read: `host_req` at edge N -> `mem_addrb` valid cycle N+1 -> `mem_data_out` valid and `host_ack = 1` cycle N+3. Maximum throughput is 1 read per 3 cycles.
- Exit: after the last ack, the mode inputs are sampled low at edge M -> RELEASE during cycle M+1 -> `core_en_out = en` from cycle M+2.

## Test plan
- **Reset:** assert `reset` mid-VERIFY read -> all outputs at their reset values, state RUN, no `host_ack`.
- **Passthrough:** in RUN with `en = 1`, `core_we_in = 1`, `core_addr_in = 10'h205`, `core_data_in = 64'hDEAD` -> `mem_web = 1`, `mem_addrb = 10'h205`, `mem_dinb = 64'hDEAD` the same cycle; `loader_busy = 0`.
- **Setup burst:** raise `setup_mem`, wait 2 cycles, then 4 consecutive `host_req` writing addresses 0..3 with data 1..4 -> four `mem_web` pulses, four `host_ack` pulses, `load_count = 4`, `core_en_out = 0` throughout. Core `core_we_in = 1` during SETUP never reaches `mem_web`.
- **Verify:** enter VERIFY, read addr 2 (RAM model returns `64'h3`) -> `mem_data_out = 3`, `host_ack` 3 cycles after the request. A second `host_req` 1 cycle after the first is dropped.
- **Release after setup:** drop `setup_mem` -> exactly one cycle of `core_reset_out = 1`, then `core_en_out = 1`. After a verify-only session -> no `core_reset_out` pulse.
- **Priority:** `setup_mem` and `verify_mem` rise together -> state goes to SETUP and `load_count` is cleared.
